// File: rtl/fetch_ctrl.sv
// Fetch-stage control: load-use stalls, branch/jump redirects and a halt/resume
// handshake for the IF stage, with saturating stall and flush counters.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        clr_cnt,
  output logic        if_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        id_bubble,
  output logic        halt_ack,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q;
  state_e      state_d;
  state_e      eff_state;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        redirect;
  logic        hazard;
  logic        stall_event;

  assign redirect = branch_taken | jump;
  assign hazard   = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Reset forces the RUN decode so the pipeline sees sane enables during reset.
  assign eff_state = reset ? RUN : state_q;

  always_comb begin
    if_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    id_bubble   = 1'b0;
    stall_event = 1'b0;
    state_d     = state_q;
    if (eff_state == RUN) begin
      if (redirect) begin
        if_flush = 1'b1;
      end else if (hazard) begin
        if_write    = 1'b0;
        ifid_write  = 1'b0;
        id_bubble   = 1'b1;
        stall_event = 1'b1;
      end else if (halt_req) begin
        if_write   = 1'b0;
        ifid_write = 1'b0;
        id_bubble  = 1'b1;
        state_d    = HALTED;
      end
    end else begin
      // Draining: an older branch may still redirect the PC, but ID stays bubbled.
      if_write   = redirect;
      ifid_write = 1'b0;
      if_flush   = redirect;
      id_bubble  = 1'b1;
      if (resume) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (clr_cnt) begin
        stall_cnt_q <= 16'd0;
        flush_cnt_q <= 16'd0;
      end else begin
        if (stall_event && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        if (if_flush && flush_cnt_q != 16'hFFFF)    flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign halt_ack  = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, compared each
// cycle against a rule-level reference model.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        branch_taken;
  logic        jump;
  logic        halt_req;
  logic        resume;
  logic        clr_cnt;
  logic        if_write;
  logic        ifid_write;
  logic        if_flush;
  logic        id_bubble;
  logic        halt_ack;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .halt_req     (halt_req),
    .resume       (resume),
    .clr_cnt      (clr_cnt),
    .if_write     (if_write),
    .ifid_write   (ifid_write),
    .if_flush     (if_flush),
    .id_bubble    (id_bubble),
    .halt_ack     (halt_ack),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // {if_write, ifid_write, if_flush, id_bubble}

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: halted flag and integer event counts.
  bit m_halted = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One cycle: predict from the rules, check at negedge, advance model at posedge.
  task automatic step();
    bit run_mode, redir, haz, stall_ev, go_halt;
    logic [3:0] e, got;
    run_mode = reset || !m_halted;
    redir    = branch_taken || jump;
    haz      = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    stall_ev = 0;
    go_halt  = 0;
    if (run_mode) begin
      if (redir)         e = 4'b1110;
      else if (haz)      begin e = 4'b0001; stall_ev = 1; end
      else if (halt_req) begin e = 4'b0001; go_halt = 1; end
      else               e = 4'b1100;
    end else begin
      e = redir ? 4'b1011 : 4'b0001;
    end
    exp_q.push_back(e);
    @(negedge clk);
    got = {if_write, ifid_write, if_flush, id_bubble};
    check_val("ctrl_outs", {12'd0, got}, {12'd0, exp_q.pop_front()});
    check_val("halt_ack", {15'd0, halt_ack}, {15'd0, m_halted});
    check_val("stall_cnt", stall_cnt, m_stall[15:0]);
    check_val("flush_cnt", flush_cnt, m_flush[15:0]);
    if (reset) begin
      m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (clr_cnt) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (stall_ev) m_stall = sat_inc(m_stall);
        if (e[1])     m_flush = sat_inc(m_flush);
      end
      if (m_halted) m_halted = !resume;
      else          m_halted = go_halt;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    reset = 0; ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    branch_taken = 0; jump = 0; halt_req = 0; resume = 0; clr_cnt = 0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs);
    ex_memread = 1; ex_rt = rd; id_rs = rs; id_rt = 5'd31 - rs;
  endtask

  task automatic drive_random();
    reset        = ($urandom_range(0, 99) == 0);
    ex_memread   = $urandom_range(0, 1);
    ex_rt        = 5'($urandom_range(0, 3));
    id_rs        = 5'($urandom_range(0, 3));
    id_rt        = 5'($urandom_range(0, 3));
    branch_taken = ($urandom_range(0, 7) == 0);
    jump         = ($urandom_range(0, 9) == 0);
    halt_req     = ($urandom_range(0, 5) == 0);
    resume       = ($urandom_range(0, 3) == 0);
    clr_cnt      = ($urandom_range(0, 49) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    reset = 1;
    #1;
    step();
    step();
    drive_idle();
    step();                                   // first fetch after reset

    drive_load_use(5'd5, 5'd5); step();       // load-use stall
    drive_idle(); step();
    check_val("load_use_cnt", stall_cnt, 16'd1);

    drive_load_use(5'd0, 5'd0); step();       // register zero never stalls
    drive_idle(); step();

    drive_load_use(5'd7, 5'd7);               // redirect beats hazard and halt
    branch_taken = 1; halt_req = 1; step();
    drive_idle(); step();

    halt_req = 1; step(); step(); step();     // halt / drain / jump / resume
    halt_req = 0; jump = 1; step();
    jump = 0; step();
    resume = 1; step();
    resume = 0; step();
    check_val("resumed_ack", {15'd0, halt_ack}, 16'd0);

    halt_req = 1; step(); step();             // resume while halt_req held
    resume = 1; step();
    resume = 0; step(); step();
    drive_idle(); resume = 1; step();
    drive_idle(); step();

    clr_cnt = 1; step();                      // saturation of stall_cnt
    drive_idle(); drive_load_use(5'd9, 5'd9);
    for (int i = 0; i < 65537; i++) step();
    drive_idle(); step();
    check_val("stall_sat", stall_cnt, 16'hFFFF);
    drive_load_use(5'd9, 5'd9); clr_cnt = 1; step();
    drive_idle(); step();
    check_val("stall_clr", stall_cnt, 16'd0);

    jump = 1; step(); step();                 // reset while halted, counters nonzero
    jump = 0; halt_req = 1; step(); step();
    reset = 1; step();
    drive_idle(); step();
    check_val("post_reset_flush", flush_cnt, 16'd0);

    for (int i = 0; i < 4000; i++) begin
      drive_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_memread  in  1  the instruction in EX is a load.
- ex_rt  in  5  destination register of the EX load.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- branch_taken  in  1  the branch resolved taken this cycle.
- jump  in  1  a jump was decoded this cycle.
- halt_req  in  1  level request to stop fetch.
- resume  in  1  single-cycle pulse to restart fetch.
- clr_cnt  in  1  synchronous clear of the performance counters.
- if_write  out  1  PC register write enable.
- ifid_write  out  1  IF/ID register write enable.
- if_flush  out  1  redirect the PC to the target and squash IF/ID.
- id_bubble  out  1  zero the ID/EX control signals.
- halt_ack  out  1  registered; high while in HALTED.
- stall_cnt  out  16  load-use stall cycles, saturating.
- flush_cnt  out  16  redirect cycles, saturating.

Function
REQ-002 The block SHALL implement a two-state FSM: RUN=1'b0 and HALTED=1'b1.
REQ-003 The block SHALL define redirect = branch_taken | jump.
REQ-004 The block SHALL define hazard = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-005 In RUN, the priority SHALL be redirect > hazard > halt_req.
REQ-006 In RUN with redirect: if_flush=1, if_write=1, ifid_write=1, id_bubble=0; this holds regardless of hazard or halt_req; the state stays RUN.
REQ-007 In RUN with hazard and no redirect: if_write=0, ifid_write=0, id_bubble=1, if_flush=0; the state stays RUN.
REQ-008 In RUN with halt_req and neither redirect nor hazard: outputs are as in REQ-010; the next state is HALTED.
REQ-009 In RUN with none of redirect, hazard or halt_req: if_write=1, ifid_write=1, id_bubble=0, if_flush=0.
REQ-010 In HALTED without redirect: if_write=0, ifid_write=0, id_bubble=1, if_flush=0; the pipeline drains with bubbles.
REQ-011 In HALTED with redirect (an older branch resolving during the drain): if_flush=1, if_write=1, ifid_write=0, id_bubble=1; the state stays HALTED.
REQ-012 In HALTED, a resume pulse SHALL move the state to RUN on the next edge.
REQ-013 A resume pulse SHALL take effect even if halt_req is still high; RUN then re-enters HALTED one cycle later, per REQ-008.
REQ-014 A resume pulse in RUN SHALL be ignored.
REQ-015 The hazard SHALL be ignored in HALTED, because ID is already bubbled.
REQ-016 All control outputs except halt_ack SHALL be combinational from the state and inputs, with zero-cycle latency.
REQ-017 halt_ack SHALL be registered and equal (state == HALTED).
REQ-018 stall_cnt SHALL increment by 1 on each edge where REQ-007 applies.
REQ-019 flush_cnt SHALL increment by 1 on each edge where if_flush=1, in either state.
REQ-020 Both counters SHALL saturate at 16'hFFFF; they never wrap.
REQ-021 clr_cnt=1 SHALL set both counters to 0 on the next edge, overriding any increment that cycle; it does not affect the FSM.
REQ-022 The block SHALL contain no other state.

Reset
REQ-023 reset=1 on an edge SHALL set the state to RUN, halt_ack=0, stall_cnt=0 and flush_cnt=0, overriding all other inputs.
REQ-024 While reset=1, the combinational outputs SHALL follow the RUN rules.
REQ-025 A reset asserted in HALTED SHALL return the block to RUN on the next edge without requiring resume.
REQ-026 After reset, the first fetch cycle SHALL have if_write=1 when no hazard, redirect or halt_req is present.

Verification
REQ-027 Load-use stall: ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle -> if_write=0, ifid_write=0, id_bubble=1 that cycle; stall_cnt 0->1.
REQ-028 Register zero: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; if_write=1, stall_cnt stays 0.
REQ-029 Simultaneous events: branch_taken=1 with a hazard and halt_req=1 in RUN -> if_flush=1, if_write=1, id_bubble=0, state stays RUN; flush_cnt +1, stall_cnt unchanged.
REQ-030 Halt/resume: halt_req=1 for 3 cycles -> halt_ack=1 from the cycle after the request; a jump pulse while HALTED -> if_flush=1, ifid_write=0; halt_req=0 then resume pulse -> halt_ack=0 one cycle later, if_write=1.
REQ-031 Saturation and clear: preload stall_cnt=16'hFFFE, apply 3 stall cycles -> stall_cnt=16'hFFFF; clr_cnt together with a stall -> stall_cnt=0.
REQ-032 Reset mid-operation: reset pulsed while HALTED with counters nonzero -> next cycle state RUN, halt_ack=0, both counters 0.
